// File: rtl/floor.sv
`default_nettype none
// ============================================================================
//  Module      : floor
//  Description : Single-cycle pipelined IEEE-754 binary32 floor (toward -inf).
//  Revision    : 1.0  initial release
// ============================================================================
module floor (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] data,
    output logic        out_valid,
    output logic [31:0] result
);

    localparam logic [7:0]  c_exp_bias    = 8'd127;
    localparam logic [7:0]  c_exp_int     = 8'd150;
    localparam logic [7:0]  c_exp_special = 8'hFF;
    localparam logic [31:0] c_neg_one     = 32'hBF80_0000;
    localparam logic [31:0] c_neg_zero    = 32'h8000_0000;

    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_frac;
    logic [7:0]  w_shamt;
    logic [22:0] w_frac_mask;
    logic [22:0] w_frac_trunc;
    logic        w_inexact;
    logic [30:0] w_mag_up;
    logic [31:0] w_floor;

    logic        r_valid;
    logic [31:0] r_result;

    assign w_sign = data[31];
    assign w_exp  = data[30:23];
    assign w_frac = data[22:0];

    // Number of fraction bits below the binary point; only meaningful for 127..149.
    assign w_shamt      = c_exp_int - w_exp;
    assign w_frac_mask  = ~(23'h7F_FFFF << w_shamt);
    assign w_frac_trunc = w_frac & ~w_frac_mask;
    assign w_inexact    = |(w_frac & w_frac_mask);

    // Adding one integer unit to {exp,frac} lets a significand overflow carry
    // straight into the exponent, leaving the fraction zero.
    assign w_mag_up = {w_exp, w_frac_trunc} + (31'd1 << w_shamt);

    always_comb begin
        w_floor = data;
        if (w_exp == c_exp_special || w_exp >= c_exp_int) begin
            w_floor = data;
        end else if (w_exp >= c_exp_bias) begin
            if (w_sign && w_inexact) begin
                w_floor = {w_sign, w_mag_up};
            end else begin
                w_floor = {w_sign, w_exp, w_frac_trunc};
            end
        end else if (!w_sign) begin
            w_floor = 32'h0000_0000;
        end else if (w_exp == 8'd0 && w_frac == 23'd0) begin
            w_floor = c_neg_zero;
        end else begin
            w_floor = c_neg_one;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_result <= 32'h0000_0000;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_floor;
            end
        end
    end

    assign out_valid = r_valid;
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_floor.sv
`default_nettype none
// Testbench for floor: random and directed operands, queue-based scoreboard.
module tb_floor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] data;
    logic        out_valid;
    logic [31:0] result;

    int n_checks;
    int n_pass;
    logic [31:0] exp_q[$];
    logic [31:0] held;
    logic        rst_at_edge;
    logic        mon_en;

    floor dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .data     (data),
        .out_valid(out_valid),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decode to an integer magnitude, floor it, re-encode.
    function automatic logic [31:0] ref_floor(input logic [31:0] x);
        logic        s;
        int          e;
        int          sig;
        int          sh;
        int          m;
        int          p;
        logic [31:0] fr;
        logic [7:0]  eo;
        s   = x[31];
        e   = int'(x[30:23]);
        sig = int'({1'b1, x[22:0]});
        if (e == 255 || e >= 150) return x;
        if (e < 127) begin
            if (!s) return 32'h0000_0000;
            if (x[30:0] == 31'd0) return 32'h8000_0000;
            return 32'hBF80_0000;
        end
        sh = 150 - e;
        m  = sig >> sh;
        if (s && ((sig & ((1 << sh) - 1)) != 0)) m = m + 1;
        p = 0;
        for (int i = 0; i < 31; i++) if (m >= (1 << i)) p = i;
        eo = 8'(127 + p);
        fr = 32'(m << (23 - p));
        return {s, eo, fr[22:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, got, want);
    endtask

    // Drive one cycle; expected output is queued only for operands actually accepted.
    task automatic drive(input logic v, input logic [31:0] d, input logic r);
        @(posedge clk);
        #1;
        in_valid = v;
        data     = d;
        rst_n    = r;
        if (v && r) exp_q.push_back(ref_floor(d));
    endtask

    always @(posedge clk) rst_at_edge = ~rst_n;

    // Monitor: sample half a cycle after each edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_at_edge) begin
                check("reset_valid", {31'd0, out_valid}, 32'd0);
                check("reset_result", result, 32'h0);
                held = 32'h0;
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    held = exp_q.pop_front();
                    check("result", result, held);
                end
            end else begin
                if (exp_q.size() > 0 && exp_q.size() > 1)
                    check("missing_valid", {31'd0, out_valid}, 32'd1);
                check("hold", result, held);
            end
        end
    end

    logic [31:0] dir_vec[$];
    logic [31:0] rnd;
    logic [7:0]  re;

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        held        = 32'h0;
        mon_en      = 1'b0;
        rst_at_edge = 1'b1;
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        data        = 32'h3F80_0000;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        drive(1'b1, 32'h4015_FC65, 1'b0);
        drive(1'b0, 32'h0, 1'b1);

        dir_vec = '{32'h3F80_0000, 32'h4015_FC65, 32'h4555_FADD, 32'h41EC_0000, 32'h42FF_999A,
                    32'h5306_BBF0, 32'h3F0F_5C29, 32'h3F25_436C, 32'h31E1_EF97, 32'h0000_0000,
                    32'hC015_FC65, 32'hBF00_0000, 32'hBFC0_0000, 32'hC040_0000,
                    32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0001, 32'h8000_0000, 32'h8000_0001,
                    32'hC07F_FFFF, 32'hCB7F_FFFF, 32'hCAFF_FFFF, 32'h4B00_0001, 32'h3F7F_FFFF};
        foreach (dir_vec[i]) drive(1'b1, dir_vec[i], 1'b1);

        // Handshake gap 1,0,1 with a junk operand during the bubble.
        drive(1'b1, 32'h4121_0000, 1'b1);
        drive(1'b0, 32'hC2AA_5555, 1'b1);
        drive(1'b1, 32'hC121_0000, 1'b1);

        // Reset mid-stream with a live operand, then resume.
        drive(1'b1, 32'h4015_FC65, 1'b1);
        drive(1'b1, 32'hBFC0_0000, 1'b0);
        drive(1'b1, 32'hBF00_0000, 1'b1);
        drive(1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 600; i++) begin
            rnd = $urandom;
            case ($urandom_range(0, 3))
                0: ;
                1, 2: begin
                    re  = 8'($urandom_range(118, 158));
                    rnd = {rnd[31], re, rnd[22:0]};
                end
                default: begin
                    re  = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'hFF;
                    rnd = {rnd[31], re, ($urandom_range(0, 1) == 0) ? 23'd0 : rnd[22:0]};
                end
            endcase
            drive($urandom_range(0, 3) != 0, rnd, $urandom_range(0, 63) != 0);
        end

        drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
